// File: rtl/int_pkg.sv
// rtl/int_pkg.sv - shared types and constants for the interrupt sequencer
//
// Provides the sequencer state encoding, the register-file indices the
// sequencer writes, the return-stack entry layout and the priority encoder
// that picks the winning pending request.

package int_pkg;

   typedef enum logic [2:0] {
      IDLE,
      WR_ID,
      WR_PC,
      RET_ID,
      RET_PC
   } int_state_e;

   localparam logic [4:0] PC_REG     = 5'd23;
   localparam logic [4:0] INT_ID_REG = 5'd25;
   localparam logic [4:0] IDLE_ID    = 5'd31;

   typedef struct packed {
      logic [31:0] pc;
      logic [4:0]  id;
   } ret_entry_t;

   // Lowest set index wins (ID 0 is the most urgent). An empty vector maps to
   // IDLE_ID, which can never beat any running level.
   function automatic logic [4:0] lowest_set(input logic [30:0] vec);
      logic [4:0] result;
      result = IDLE_ID;
      for (int i = 30; i >= 0; i--) begin
         if (vec[i]) begin
            result = i[4:0];
         end
      end
      return result;
   endfunction

endpackage

// File: rtl/interrupt_sequencer_if.sv
// rtl/interrupt_sequencer_if.sv - register-file write port bundle
//
// wb_req   : sequencer requests a register write
// wb_grant : write port accepts wb_addr/wb_data this cycle
// wb_addr  : register index to write
// wb_data  : value to write
// master = sequencer side, slave = register-file side.

interface interrupt_sequencer_if;

   logic        wb_req;
   logic        wb_grant;
   logic [4:0]  wb_addr;
   logic [31:0] wb_data;

   modport master (
      output wb_req,
      output wb_addr,
      output wb_data,
      input  wb_grant
   );

   modport slave (
      input  wb_req,
      input  wb_addr,
      input  wb_data,
      output wb_grant
   );

endinterface

// File: rtl/ret_stack.sv
// rtl/ret_stack.sv - LIFO of interrupted contexts for nested interrupts
//
// clk, rst_n : clock, asynchronous active-low reset
// push       : store push_data on top (ignored when full)
// pop        : discard the top entry (ignored when empty)
// push_data  : entry to store
// top        : current top entry, zero when empty
// depth      : number of stored entries
// full/empty : occupancy flags

module ret_stack
   import int_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   push,
   input  logic                   pop,
   input  ret_entry_t             push_data,
   output ret_entry_t             top,
   output logic [$clog2(DEPTH):0] depth,
   output logic                   full,
   output logic                   empty
);

   localparam int AW = $clog2(DEPTH);

   ret_entry_t     mem [DEPTH];
   logic [AW:0]    depth_m1;

   assign depth_m1 = depth - (AW + 1)'(1);
   assign full     = (depth == (AW + 1)'(DEPTH));
   assign empty    = (depth == '0);
   assign top      = empty ? '0 : mem[depth_m1[AW-1:0]];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         depth <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
      end else if (push && !full) begin
         mem[depth[AW-1:0]] <= push_data;
         depth              <= depth + (AW + 1)'(1);
      end else if (pop && !empty) begin
         depth <= depth_m1;
      end
   end

endmodule

// File: rtl/interrupt_sequencer.sv
// rtl/interrupt_sequencer.sv - edge-latched interrupt entry/return write sequencer
//
// clk, rst_n     : clock, asynchronous active-low reset
// irq_in         : interrupt lines, bit i = ID i, rising-edge sensitive
// gie            : global interrupt enable
// current_int_id : running interrupt level (31 = none)
// ivt_b_p        : vector table base; vector = base + 4*ID
// pc_from_reg    : PC saved on entry
// reti           : return-from-interrupt pulse, honoured only in IDLE
// wb             : register-file write port (master side)
// stall_core     : core holds fetch/issue while a sequence runs
// irq_ack        : one-hot pulse naming the ID that was taken
// reti_err       : pulse when reti arrives with nothing to return to
// nest_depth     : return-stack occupancy

module interrupt_sequencer
   import int_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [30:0]             irq_in,
   input  logic                    gie,
   input  logic [4:0]              current_int_id,
   input  logic [31:0]             ivt_b_p,
   input  logic [31:0]             pc_from_reg,
   input  logic                    reti,
   interrupt_sequencer_if.master   wb,
   output logic                    stall_core,
   output logic [30:0]             irq_ack,
   output logic                    reti_err,
   output logic [$clog2(DEPTH):0]  nest_depth
);

   int_state_e   state;
   logic [30:0]  irq_prev;
   logic [30:0]  pending;
   logic [30:0]  pend_clr;
   logic [4:0]   tgt_id;
   logic [4:0]   sel_id;
   logic         take;
   logic         reti_ok;
   logic         push;
   logic         pop;
   logic         full;
   logic         empty;
   ret_entry_t   top;
   ret_entry_t   push_entry;

   assign sel_id  = lowest_set(pending);
   assign take    = gie && (|pending) && (sel_id < current_int_id) && !full;
   assign reti_ok = reti && !empty;

   // reti outranks a new take, so a push only happens when no reti is seen.
   assign push       = (state == IDLE) && !reti && take;
   assign pop        = (state == RET_PC) && wb.wb_grant;
   assign push_entry = '{pc: pc_from_reg, id: current_int_id};

   // Stall goes high in the deciding IDLE cycle so the core does not move the
   // PC that was just pushed.
   assign stall_core = (state != IDLE) || push || ((state == IDLE) && reti_ok);

   assign pend_clr = ((state == WR_ID) && wb.wb_grant) ? (31'd1 << tgt_id) : '0;

   ret_stack #(
      .DEPTH (DEPTH)
   ) u_ret_stack (
      .clk       (clk),
      .rst_n     (rst_n),
      .push      (push),
      .pop       (pop),
      .push_data (push_entry),
      .top       (top),
      .depth     (nest_depth),
      .full      (full),
      .empty     (empty)
   );

   // A fresh edge on a bit being cleared keeps it pending (set wins).
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         irq_prev <= '0;
         pending  <= '0;
      end else begin
         irq_prev <= irq_in;
         pending  <= (pending & ~pend_clr) | (irq_in & ~irq_prev);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         tgt_id     <= '0;
         wb.wb_req  <= 1'b0;
         wb.wb_addr <= '0;
         wb.wb_data <= '0;
         irq_ack    <= '0;
         reti_err   <= 1'b0;
      end else begin
         irq_ack  <= '0;
         reti_err <= 1'b0;
         case (state)
            IDLE: begin
               if (reti) begin
                  if (empty) begin
                     reti_err <= 1'b1;
                  end else begin
                     state      <= RET_ID;
                     wb.wb_req  <= 1'b1;
                     wb.wb_addr <= INT_ID_REG;
                     wb.wb_data <= {27'b0, top.id};
                  end
               end else if (take) begin
                  state      <= WR_ID;
                  tgt_id     <= sel_id;
                  wb.wb_req  <= 1'b1;
                  wb.wb_addr <= INT_ID_REG;
                  wb.wb_data <= {27'b0, sel_id};
               end
            end
            WR_ID: begin
               if (wb.wb_grant) begin
                  state      <= WR_PC;
                  irq_ack    <= 31'd1 << tgt_id;
                  wb.wb_addr <= PC_REG;
                  wb.wb_data <= ivt_b_p + {25'b0, tgt_id, 2'b00};
               end
            end
            RET_ID: begin
               if (wb.wb_grant) begin
                  state      <= RET_PC;
                  wb.wb_addr <= PC_REG;
                  wb.wb_data <= top.pc;
               end
            end
            WR_PC, RET_PC: begin
               if (wb.wb_grant) begin
                  state      <= IDLE;
                  wb.wb_req  <= 1'b0;
                  wb.wb_addr <= '0;
                  wb.wb_data <= '0;
               end
            end
            default: begin
               state      <= IDLE;
               wb.wb_req  <= 1'b0;
               wb.wb_addr <= '0;
               wb.wb_data <= '0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_interrupt_sequencer.sv
// tb/tb_interrupt_sequencer.sv - directed self-checking bench for interrupt_sequencer

module tb_interrupt_sequencer;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [30:0] irq_in;
   logic        gie;
   logic [4:0]  current_int_id;
   logic [31:0] ivt_b_p;
   logic [31:0] pc_from_reg;
   logic        reti;
   logic        stall_core;
   logic [30:0] irq_ack;
   logic        reti_err;
   logic [2:0]  nest_depth;

   int vectors     = 0;
   int miscompares = 0;

   interrupt_sequencer_if wb ();

   interrupt_sequencer #(
      .DEPTH (4)
   ) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .irq_in         (irq_in),
      .gie            (gie),
      .current_int_id (current_int_id),
      .ivt_b_p        (ivt_b_p),
      .pc_from_reg    (pc_from_reg),
      .reti           (reti),
      .wb             (wb),
      .stall_core     (stall_core),
      .irq_ack        (irq_ack),
      .reti_err       (reti_err),
      .nest_depth     (nest_depth)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: bench did not finish");
      $fatal(1);
   end

   task automatic step();
      @(negedge clk);
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic wait_req(input string tag);
      int n;
      n = 0;
      while (wb.wb_req !== 1'b1 && n < 10) begin
         step();
         n++;
      end
      chk({tag, "_req"}, {31'b0, wb.wb_req}, 32'd1);
   endtask

   // Entry or return sequence with the grant held high: ID write then PC write.
   task automatic expect_pair(input string tag, input logic [31:0] id_val, input logic [31:0] pc_val);
      wait_req(tag);
      chk({tag, "_addr_id"}, {27'b0, wb.wb_addr}, 32'd25);
      chk({tag, "_data_id"}, wb.wb_data, id_val);
      step();
      chk({tag, "_addr_pc"}, {27'b0, wb.wb_addr}, 32'd23);
      chk({tag, "_data_pc"}, wb.wb_data, pc_val);
      step();
      chk({tag, "_req_done"}, {31'b0, wb.wb_req}, 32'd0);
   endtask

   task automatic raise_irq(input int id);
      irq_in[id] = 1'b1;
      step();
      irq_in[id] = 1'b0;
   endtask

   task automatic do_reset();
      rst_n          = 1'b0;
      irq_in         = '0;
      reti           = 1'b0;
      gie            = 1'b1;
      current_int_id = 5'd31;
      ivt_b_p        = 32'h1000;
      pc_from_reg    = 32'h200;
      wb.wb_grant    = 1'b1;
      step();
      step();
      rst_n = 1'b1;
      step();
   endtask

   initial begin
      rst_n          = 1'b0;
      irq_in         = '0;
      reti           = 1'b0;
      gie            = 1'b1;
      current_int_id = 5'd31;
      ivt_b_p        = 32'h1000;
      pc_from_reg    = 32'h200;
      wb.wb_grant    = 1'b1;
      step();
      step();

      // reset state
      chk("rst_req",   {31'b0, wb.wb_req}, 32'd0);
      chk("rst_addr",  {27'b0, wb.wb_addr}, 32'd0);
      chk("rst_data",  wb.wb_data, 32'd0);
      chk("rst_stall", {31'b0, stall_core}, 32'd0);
      chk("rst_ack",   {1'b0, irq_ack}, 32'd0);
      chk("rst_err",   {31'b0, reti_err}, 32'd0);
      chk("rst_depth", {29'b0, nest_depth}, 32'd0);
      rst_n = 1'b1;
      step();

      // basic take of ID 5, cycle exact
      raise_irq(5);
      #1;
      chk("take_stall_decide", {31'b0, stall_core}, 32'd1);
      chk("take_req_decide",   {31'b0, wb.wb_req}, 32'd0);
      step();
      chk("take_req",    {31'b0, wb.wb_req}, 32'd1);
      chk("take_addr",   {27'b0, wb.wb_addr}, 32'd25);
      chk("take_data",   wb.wb_data, 32'd5);
      chk("take_depth",  {29'b0, nest_depth}, 32'd1);
      chk("take_ack0",   {1'b0, irq_ack}, 32'd0);
      step();
      chk("take_addr_pc", {27'b0, wb.wb_addr}, 32'd23);
      chk("take_vector",  wb.wb_data, 32'h1014);
      chk("take_ack",     {1'b0, irq_ack}, 32'h20);
      current_int_id = 5'd5;
      step();
      chk("take_idle_req",   {31'b0, wb.wb_req}, 32'd0);
      chk("take_idle_ack",   {1'b0, irq_ack}, 32'd0);
      chk("take_idle_stall", {31'b0, stall_core}, 32'd0);
      chk("take_idle_depth", {29'b0, nest_depth}, 32'd1);

      // return from ID 5
      reti = 1'b1;
      #1;
      chk("ret_stall", {31'b0, stall_core}, 32'd1);
      step();
      reti = 1'b0;
      expect_pair("ret", 32'd31, 32'h200);
      chk("ret_depth", {29'b0, nest_depth}, 32'd0);
      current_int_id = 5'd31;

      // reti on empty stack
      reti = 1'b1;
      #1;
      chk("err_stall", {31'b0, stall_core}, 32'd0);
      step();
      reti = 1'b0;
      chk("err_pulse", {31'b0, reti_err}, 32'd1);
      chk("err_req",   {31'b0, wb.wb_req}, 32'd0);
      step();
      chk("err_clear", {31'b0, reti_err}, 32'd0);
      chk("err_req2",  {31'b0, wb.wb_req}, 32'd0);

      // priority: 3 and 9 together, then level checks against running 3
      do_reset();
      irq_in[3] = 1'b1;
      irq_in[9] = 1'b1;
      step();
      irq_in = '0;
      expect_pair("prio3", 32'd3, 32'h100C);
      current_int_id = 5'd3;
      raise_irq(7);
      step();
      step();
      chk("low7_req",   {31'b0, wb.wb_req}, 32'd0);
      chk("low7_stall", {31'b0, stall_core}, 32'd0);
      chk("low7_depth", {29'b0, nest_depth}, 32'd1);
      raise_irq(1);
      expect_pair("pre1", 32'd1, 32'h1004);
      chk("pre1_depth", {29'b0, nest_depth}, 32'd2);

      // backpressure in WR_ID
      do_reset();
      wb.wb_grant = 1'b0;
      raise_irq(4);
      wait_req("bp");
      for (int i = 0; i < 5; i++) begin
         chk("bp_addr",  {27'b0, wb.wb_addr}, 32'd25);
         chk("bp_data",  wb.wb_data, 32'd4);
         chk("bp_stall", {31'b0, stall_core}, 32'd1);
         chk("bp_ack",   {1'b0, irq_ack}, 32'd0);
         step();
      end
      wb.wb_grant = 1'b1;
      step();
      chk("bp_ack_pulse", {1'b0, irq_ack}, 32'h10);
      chk("bp_addr_pc",   {27'b0, wb.wb_addr}, 32'd23);
      chk("bp_vector",    wb.wb_data, 32'h1010);
      step();
      chk("bp_done", {31'b0, wb.wb_req}, 32'd0);

      // gie gating
      do_reset();
      gie = 1'b0;
      raise_irq(2);
      step();
      step();
      step();
      chk("gie0_req",   {31'b0, wb.wb_req}, 32'd0);
      chk("gie0_stall", {31'b0, stall_core}, 32'd0);
      chk("gie0_depth", {29'b0, nest_depth}, 32'd0);
      gie = 1'b1;
      expect_pair("gie1", 32'd2, 32'h1008);
      chk("gie1_depth", {29'b0, nest_depth}, 32'd1);

      // fill the stack, block preemption, pop to release
      do_reset();
      pc_from_reg = 32'h410;
      raise_irq(10);
      expect_pair("n10", 32'd10, 32'h1028);
      current_int_id = 5'd10;
      pc_from_reg = 32'h420;
      raise_irq(8);
      expect_pair("n8", 32'd8, 32'h1020);
      current_int_id = 5'd8;
      pc_from_reg = 32'h430;
      raise_irq(6);
      expect_pair("n6", 32'd6, 32'h1018);
      current_int_id = 5'd6;
      pc_from_reg = 32'h440;
      raise_irq(4);
      expect_pair("n4", 32'd4, 32'h1010);
      current_int_id = 5'd4;
      chk("full_depth", {29'b0, nest_depth}, 32'd4);
      raise_irq(2);
      step();
      step();
      chk("full_req",   {31'b0, wb.wb_req}, 32'd0);
      chk("full_stall", {31'b0, stall_core}, 32'd0);
      chk("full_depth2", {29'b0, nest_depth}, 32'd4);
      reti = 1'b1;
      step();
      reti = 1'b0;
      expect_pair("pop4", 32'd6, 32'h440);
      chk("pop_depth", {29'b0, nest_depth}, 32'd3);
      current_int_id = 5'd6;
      expect_pair("late2", 32'd2, 32'h1008);
      chk("late2_depth", {29'b0, nest_depth}, 32'd4);

      // asynchronous reset while in WR_PC
      do_reset();
      raise_irq(2);
      wait_req("ar");
      step();
      chk("ar_in_wrpc", {27'b0, wb.wb_addr}, 32'd23);
      rst_n = 1'b0;
      #1;
      chk("ar_req",   {31'b0, wb.wb_req}, 32'd0);
      chk("ar_stall", {31'b0, stall_core}, 32'd0);
      chk("ar_depth", {29'b0, nest_depth}, 32'd0);
      chk("ar_data",  wb.wb_data, 32'd0);
      step();
      rst_n = 1'b1;
      step();
      step();
      chk("ar_no_write", {31'b0, wb.wb_req}, 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
